// File: rtl/nd_2to1_pkg.sv
// rtl/nd_2to1_pkg.sv - shared node-network constants and types for the 2-to-1 merger
//
// Purpose: global message-field widths, on/off levels, the message-bundle width
//          macro, and the channel identifier used by the round-robin pointer.
// Ports:   none (package).

`ifndef NS_GLOBAL_DEFS
`define NS_GLOBAL_DEFS
`define NS_ON 1'b1
`define NS_OFF 1'b0
`define NS_ADDRESS_SIZE 8
`define NS_DATA_SIZE 32
`define NS_REDUN_SIZE 8
`define NS_MSG_SIZE(asz, dsz, rsz) ((asz) * 2 + (dsz) + (rsz))
`endif

package nd_2to1_pkg;

    localparam int NS_ASZ = `NS_ADDRESS_SIZE;
    localparam int NS_DSZ = `NS_DATA_SIZE;
    localparam int NS_RSZ = `NS_REDUN_SIZE;

    // Input channel identifier; also the encoding of the round-robin pointer.
    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_e;

    // The channel that gets preference after a grant to channel c.
    function automatic ch_e other_ch(input ch_e c);
        return (c == CH0) ? CH1 : CH0;
    endfunction

endpackage

// File: rtl/nd_msg_fifo.sv
// rtl/nd_msg_fifo.sv - message FIFO used by the 2-to-1 merger
//
// Purpose: FSZ-deep first-in first-out store of whole message bundles.
//          Head is presented combinationally on data_out; pop advances it.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset (empties the FIFO)
//   push      in   write data_in at the tail (ignored when full)
//   data_in   in   message to write
//   pop       in   discard the head (ignored when empty)
//   data_out  out  head message
//   full      out  count == FSZ
//   empty     out  count == 0
//   count     out  messages held, $clog2(FSZ)+1 bits

module nd_msg_fifo
    import nd_2to1_pkg::*;
#(
    parameter int FSZ = 4,
    parameter int MW  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [MW-1:0]        data_in,
    input  logic                 pop,
    output logic [MW-1:0]        data_out,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(FSZ):0] count
);

    localparam int PW = $clog2(FSZ);

    logic [MW-1:0] mem_q [FSZ];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == (PW + 1)'(FSZ));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign data_out = mem_q[rd_ptr_q];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // FSZ is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never presents its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/nd_2to1.sv
// rtl/nd_2to1.sv - two-input round-robin message merger with 4-phase req/ack channels
//
// Purpose: accepts messages from two 4-phase input channels, arbitrates
//          round-robin, queues them in nd_msg_fifo and re-emits them in
//          acceptance order on one 4-phase output channel.
// Ports:
//   gch_clk / gch_reset  in   clock / asynchronous active-low reset
//   gch_ready            out  high from the first edge after reset release
//   rcvN_req             in   input channel N request (synchronised)
//   rcvN_ack             out  input channel N acknowledge
//   rcvN_src/dst/dat/red in   input channel N message fields
//   snd0_req             out  output request
//   snd0_ack             in   output acknowledge (synchronised)
//   snd0_src/dst/dat/red out  output message fields, held between loads

module nd_2to1
    import nd_2to1_pkg::*;
#(
    parameter int FSZ       = 4,
    parameter int ASZ       = NS_ASZ,
    parameter int DSZ       = NS_DSZ,
    parameter int RSZ       = NS_RSZ,
    parameter int SYNC_STGS = 2
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [ASZ-1:0] rcv0_src,
    input  logic [ASZ-1:0] rcv0_dst,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv1_req,
    output logic           rcv1_ack,
    input  logic [ASZ-1:0] rcv1_src,
    input  logic [ASZ-1:0] rcv1_dst,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,
    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red
);

    localparam int MW = `NS_MSG_SIZE(ASZ, DSZ, RSZ);
    localparam int CW = $clog2(FSZ) + 1;

    logic [SYNC_STGS-1:0] req0_sync_q, req1_sync_q, ack_sync_q;
    logic                 sreq0, sreq1, sack;

    logic          ready_q;
    logic          rcv0_ack_q, rcv0_ack_d;
    logic          rcv1_ack_q, rcv1_ack_d;
    ch_e           ptr_q, ptr_d;
    logic          snd_req_q, snd_req_d;
    logic [MW-1:0] snd_msg_q, snd_msg_d;

    logic          elig0, elig1, grant0, grant1;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [MW-1:0] msg0, msg1, fifo_din, fifo_dout;
    logic [CW-1:0] unused_fifo_count;

    assign sreq0 = req0_sync_q[SYNC_STGS-1];
    assign sreq1 = req1_sync_q[SYNC_STGS-1];
    assign sack  = ack_sync_q[SYNC_STGS-1];

    assign msg0 = {rcv0_src, rcv0_dst, rcv0_dat, rcv0_red};
    assign msg1 = {rcv1_src, rcv1_dst, rcv1_dat, rcv1_red};

    // A channel is eligible only once its previous ack has been withdrawn.
    assign elig0 = sreq0 & ~rcv0_ack_q & ready_q;
    assign elig1 = sreq1 & ~rcv1_ack_q & ready_q;

    // Full is the registered count, so a pop this cycle cannot free a slot
    // for a push in the same cycle.
    assign grant0 = ~fifo_full & elig0 & (~elig1 | (ptr_q == CH0));
    assign grant1 = ~fifo_full & elig1 & (~elig0 | (ptr_q == CH1));

    assign fifo_push = grant0 | grant1;
    assign fifo_din  = grant0 ? msg0 : msg1;

    // Load the output only after the previous handshake has fully returned to zero.
    assign fifo_pop = ~snd_req_q & ~sack & ~fifo_empty;

    always_comb begin
        rcv0_ack_d = rcv0_ack_q;
        rcv1_ack_d = rcv1_ack_q;
        ptr_d      = ptr_q;
        snd_req_d  = snd_req_q;
        snd_msg_d  = snd_msg_q;

        if (grant0) begin
            rcv0_ack_d = `NS_ON;
        end else if (!sreq0) begin
            rcv0_ack_d = `NS_OFF;
        end

        if (grant1) begin
            rcv1_ack_d = `NS_ON;
        end else if (!sreq1) begin
            rcv1_ack_d = `NS_OFF;
        end

        if (fifo_push) begin
            ptr_d = other_ch(grant0 ? CH0 : CH1);
        end

        if (fifo_pop) begin
            snd_req_d = `NS_ON;
            snd_msg_d = fifo_dout;
        end else if (snd_req_q && sack) begin
            snd_req_d = `NS_OFF;
        end
    end

    always_ff @(posedge gch_clk or negedge gch_reset) begin
        if (!gch_reset) begin
            req0_sync_q <= '0;
            req1_sync_q <= '0;
            ack_sync_q  <= '0;
            ready_q     <= `NS_OFF;
            rcv0_ack_q  <= `NS_OFF;
            rcv1_ack_q  <= `NS_OFF;
            ptr_q       <= CH0;
            snd_req_q   <= `NS_OFF;
            snd_msg_q   <= '0;
        end else begin
            req0_sync_q <= {req0_sync_q[SYNC_STGS-2:0], rcv0_req};
            req1_sync_q <= {req1_sync_q[SYNC_STGS-2:0], rcv1_req};
            ack_sync_q  <= {ack_sync_q[SYNC_STGS-2:0], snd0_ack};
            ready_q     <= `NS_ON;
            rcv0_ack_q  <= rcv0_ack_d;
            rcv1_ack_q  <= rcv1_ack_d;
            ptr_q       <= ptr_d;
            snd_req_q   <= snd_req_d;
            snd_msg_q   <= snd_msg_d;
        end
    end

    nd_msg_fifo #(
        .FSZ (FSZ),
        .MW  (MW)
    ) u_fifo (
        .clk      (gch_clk),
        .rst_n    (gch_reset),
        .push     (fifo_push),
        .data_in  (fifo_din),
        .pop      (fifo_pop),
        .data_out (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (unused_fifo_count)
    );

    assign gch_ready = ready_q;
    assign rcv0_ack  = rcv0_ack_q;
    assign rcv1_ack  = rcv1_ack_q;
    assign snd0_req  = snd_req_q;
    assign {snd0_src, snd0_dst, snd0_dat, snd0_red} = snd_msg_q;

endmodule
